menu_mem_arb: RTL and testbench
===============================

Name: menu_mem_arb

Overview:
- Single-port SDRAM access scheduler for the MENU core.
- Shares one toggle-handshake SDRAM port between two requesters:
  - the byte-wide BMP upload stream from the SPI data loader;
  - the video line prefetcher, which fills a line buffer ahead of the raster.
- Replaces direct wiring of upload and video to separate SDRAM ports. All logic is in the clk_ram domain.

Parameters:
- WQ_DEPTH, 8: write-queue entries (power of 2, ≥2).
- LINE_WORDS, 1024: 16-bit words fetched per video line (512 px × 2 words).
- AW, 23: SDRAM word-address width.

Ports:
- clk_ram  in  1  SDRAM/system clock.
- reset  in  1  Synchronous, active-high reset.
- up_wr  in  1  Single-cycle pulse, upload byte valid.
- up_addr  in  24  Byte address, relative to bitmap data start.
- up_data  in  8  Upload byte.
- up_ovf  out  1  Sticky: a byte arrived while the queue was full.
- line_req  in  1  Single-cycle pulse: fetch a line.
- line_base  in  AW  Word address of the line's first word.
- line_busy  out  1  Line fetch in progress.
- line_ovr  out  1  Sticky: line_req arrived while a request was already pending.
- lb_we  out  1  Line-buffer write strobe.
- lb_addr  out  10  Line-buffer word index.
- lb_data  out  16  Line-buffer data.
- mem_req  out  1  Toggle request.
- mem_ack  in  1  Toggle acknowledge; equals mem_req when done.
- mem_we  out  1  1 = write.
- mem_a  out  AW  Word address.
- mem_ds  out  2  Byte strobes {hi, lo}.
- mem_d  out  16  Write data.
- mem_q  in  16  Read data, valid in the cycle mem_ack becomes equal to mem_req.

Behaviour:
- Reset values:
  - all outputs 0 and mem_req = 0;
  - queue empty, FSM in IDLE, pending-line flag clear, round-robin pointer = write;
  - a reset mid-access abandons the access, and mem_req returns to 0.
- Upload path:
  - Each up_wr pushes {up_addr[23:1], ds, data} into the queue.
  - ds = 2'b01 if up_addr[0] = 0, else 2'b10. The byte is replicated on both halves of mem_d.
  - Push when the queue is full: the byte is dropped and up_ovf is set.
  - Push and pop in the same cycle are both honoured, including when the queue is full.
- Line path:
  - line_req while idle starts a fetch immediately.
  - line_req while busy with no pending request latches {line_base} as pending.
  - line_req while a request is already pending overwrites it and sets line_ovr.
  - line_busy is high from the cycle after line_req until the cycle after the last lb_we.
- FSM states:
  - IDLE: when the mem port is free (mem_ack == mem_req), select the next access.
  - WR: toggle mem_req with mem_we = 1 and the queue head; pop the queue.
  - RD: toggle mem_req with mem_we = 0 and mem_a = base + idx.
  - WAIT: hold until mem_ack == mem_req.
    - After a read: lb_we = 1 for one cycle, lb_addr = idx, lb_data = mem_q; idx increments.
    - When idx reaches LINE_WORDS-1, the line is done.
    - Return to IDLE.
- Selection in IDLE:
  - Only one requester active: serve it.
  - Both active: serve the one the round-robin pointer names, then flip the pointer.
  - Exception: if the queue holds ≥ WQ_DEPTH-2 entries, the write wins regardless of the pointer.
- Line completion:
  - A pending request, if any, starts on the next IDLE entry.
  - idx resets to 0 at the start of every line.
- Timing:
  - mem_a, mem_we, mem_ds and mem_d are registered and stable from the mem_req toggle until the matching ack.
  - Minimum 3 clocks per access (IDLE → WR/RD → WAIT).
- Arithmetic: base + idx is computed modulo 2^AW (address wrap), with no error flag.

Optional Feature:
- Macro MENU_MEM_ARB_WRCOMBINE_EN.
- Defined:
  - A queue entry with ds = 01 whose next entry has the same word address and ds = 10 is merged.
  - The merged access is one write with ds = 11 and mem_d = {hi, lo}; both entries pop in the same cycle.
  - Halves the access count for sequential uploads.
- Undefined: every byte is a separate write.

Decomposition:
- Package menu_mem_pkg holds:
  - the FSM state enum (IDLE, WR, RD, WAIT);
  - the queue entry struct {a[AW-1:0], ds[1:0], d[7:0]};
  - localparam RR_WR = 0 / RR_RD = 1.
- Sub-module menu_mem_wfifo: synchronous FIFO with full, empty and a count output (count feeds the urgency threshold), plus a 2-entry head peek for write combining.

Test Plan:
- Bytes 0x11 then 0x22 at up_addr 0 and 1, video idle:
  - without the macro: two writes, mem_a = 0, ds = 01 then ds = 10;
  - with the macro: one write, ds = 11, mem_d = 0x2211.
- line_req with line_base = 0x100 and a memory model returning q = addr:
  - exactly 1024 lb_we pulses, with lb_data = 0x100 + lb_addr;
  - line_busy falls one cycle after the last pulse.
- Continuous uploads during a line fetch with ack latency 2:
  - grants alternate WR/RD;
  - the queue reaches depth 6 and a WR is forced;
  - up_ovf stays 0.
- 9 up_wr in consecutive cycles with mem_ack frozen:
  - entries 1–8 are queued (one may already be in flight);
  - the dropped byte sets up_ovf;
  - queue order is preserved after ack resumes.
- Three line_req pulses during one fetch: line_ovr = 1, and the second fetch uses the third base.
- reset asserted mid-WAIT: all outputs 0 on the next cycle; after release, a new upload write issues correctly.

Source files
------------

// File: rtl/menu_mem_pkg.sv
// Shared types for the MENU SDRAM scheduler: FSM states, write-queue entry, round-robin codes.
package menu_mem_pkg;

   localparam int MEM_AW = 23;

   typedef enum logic [1:0] {IDLE, WR, RD, WAIT} state_e;

   typedef struct packed {
      logic [MEM_AW-1:0] a;
      logic [1:0]        ds;
      logic [7:0]        d;
   } wq_entry_t;

   localparam logic RR_WR = 1'b0;
   localparam logic RR_RD = 1'b1;

   // Byte lane strobe {hi, lo} for a byte address LSB.
   function automatic logic [1:0] byte_ds(input logic lsb);
      return lsb ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/menu_mem_wfifo.sv
// Upload write queue: synchronous FIFO with occupancy count and a two-entry head peek.
module menu_mem_wfifo
   import menu_mem_pkg::*;
#(
   parameter int DEPTH = 8,
   localparam int PW = $clog2(DEPTH),
   localparam int CW = PW + 1
) (
   input  logic          clk_ram,
   input  logic          reset,
   input  logic          push_i,
   input  wq_entry_t     push_data_i,
   input  logic          pop_i,
   input  logic          pop2_i,
   output wq_entry_t     head0_o,
   output wq_entry_t     head1_o,
   output logic          full_o,
   output logic          empty_o,
   output logic [CW-1:0] count_o
);

   wq_entry_t     mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q;
   logic          push_ok;
   logic [1:0]    n_pop;

   assign n_pop   = !pop_i ? 2'd0 : (pop2_i ? 2'd2 : 2'd1);
   // A pop in the same cycle frees the slot, so a push into a full queue is still taken.
   assign push_ok = push_i && (count_q != CW'(DEPTH) || pop_i);

   always_ff @(posedge clk_ram) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
         rd_ptr_q <= rd_ptr_q + PW'(n_pop);
         count_q  <= count_q + CW'(push_ok) - CW'(n_pop);
      end
   end

   always_ff @(posedge clk_ram) begin
      if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
   end

   assign head0_o = mem_q[rd_ptr_q];
   assign head1_o = mem_q[rd_ptr_q + PW'(1)];
   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;

endmodule

// File: rtl/menu_mem_arb.sv
// Shares one toggle-handshake SDRAM port between the BMP upload queue and the video line prefetcher.
// Define MENU_MEM_ARB_WRCOMBINE_EN to merge lo/hi byte pairs of one word into a single write.
module menu_mem_arb
   import menu_mem_pkg::*;
#(
   parameter int WQ_DEPTH   = 8,
   parameter int LINE_WORDS = 1024,
   parameter int AW         = MEM_AW
) (
   input  logic          clk_ram,
   input  logic          reset,
   input  logic          up_wr,
   input  logic [23:0]   up_addr,
   input  logic [7:0]    up_data,
   output logic          up_ovf,
   input  logic          line_req,
   input  logic [AW-1:0] line_base,
   output logic          line_busy,
   output logic          line_ovr,
   output logic          lb_we,
   output logic [9:0]    lb_addr,
   output logic [15:0]   lb_data,
   output logic          mem_req,
   input  logic          mem_ack,
   output logic          mem_we,
   output logic [AW-1:0] mem_a,
   output logic [1:0]    mem_ds,
   output logic [15:0]   mem_d,
   input  logic [15:0]   mem_q
);

   localparam int CW = $clog2(WQ_DEPTH) + 1;
   localparam int IW = $clog2(LINE_WORDS);
`ifdef MENU_MEM_ARB_WRCOMBINE_EN
   localparam bit WRCOMBINE = 1'b1;
`else
   localparam bit WRCOMBINE = 1'b0;
`endif

   wq_entry_t     wq_push_data, wq_head0, wq_head1;
   logic          wq_pop, wq_pop2, wq_full, wq_empty;
   logic [CW-1:0] wq_count;

   assign wq_push_data = '{a: up_addr[23:1], ds: byte_ds(up_addr[0]), d: up_data};

   menu_mem_wfifo #(.DEPTH(WQ_DEPTH)) u_wfifo (
      .clk_ram     (clk_ram),
      .reset       (reset),
      .push_i      (up_wr),
      .push_data_i (wq_push_data),
      .pop_i       (wq_pop),
      .pop2_i      (wq_pop2),
      .head0_o     (wq_head0),
      .head1_o     (wq_head1),
      .full_o      (wq_full),
      .empty_o     (wq_empty),
      .count_o     (wq_count)
   );

   state_e        state_q, state_d;
   logic          rr_q, rr_d, is_rd_q, is_rd_d;
   logic          mem_req_q, mem_req_d, mem_we_q, mem_we_d;
   logic [AW-1:0] mem_a_q, mem_a_d;
   logic [1:0]    mem_ds_q, mem_ds_d;
   logic [15:0]   mem_d_q, mem_d_d;
   logic          lb_we_q, lb_we_d;
   logic [9:0]    lb_addr_q, lb_addr_d;
   logic [15:0]   lb_data_q, lb_data_d;
   logic [IW-1:0] idx_q, idx_d;
   logic          act_q, act_d, pend_q, pend_d, ovr_q, ovr_d, ovf_q, ovf_d;
   logic [AW-1:0] base_q, base_d, pbase_q, pbase_d;
   logic          port_free, urgent, merge, line_done;

   assign port_free = (mem_ack == mem_req_q);
   assign urgent    = (wq_count >= CW'(WQ_DEPTH - 2));
   assign merge     = WRCOMBINE && wq_head0.ds == 2'b01 && wq_count >= CW'(2) &&
                      wq_head1.a == wq_head0.a && wq_head1.ds == 2'b10;

   always_comb begin
      state_d   = state_q;
      rr_d      = rr_q;
      is_rd_d   = is_rd_q;
      mem_req_d = mem_req_q;
      mem_we_d  = mem_we_q;
      mem_a_d   = mem_a_q;
      mem_ds_d  = mem_ds_q;
      mem_d_d   = mem_d_q;
      lb_we_d   = 1'b0;
      lb_addr_d = lb_addr_q;
      lb_data_d = lb_data_q;
      idx_d     = idx_q;
      act_d     = act_q;
      base_d    = base_q;
      pend_d    = pend_q;
      pbase_d   = pbase_q;
      ovr_d     = ovr_q;
      ovf_d     = ovf_q | (up_wr & wq_full & ~wq_pop);
      wq_pop    = 1'b0;
      wq_pop2   = 1'b0;
      line_done = 1'b0;

      case (state_q)
         IDLE: begin
            if (port_free) begin
               // A nearly full queue overrides the round-robin pointer.
               if (!wq_empty && (!act_q || urgent || rr_q == RR_WR)) begin
                  state_d = WR;
                  if (act_q) rr_d = RR_RD;
               end else if (act_q) begin
                  state_d = RD;
                  if (!wq_empty) rr_d = RR_WR;
               end
            end
         end
         WR: begin
            mem_req_d = ~mem_req_q;
            mem_we_d  = 1'b1;
            mem_a_d   = AW'(wq_head0.a);
            mem_ds_d  = wq_head0.ds;
            mem_d_d   = {wq_head0.d, wq_head0.d};
            wq_pop    = 1'b1;
            if (merge) begin
               mem_ds_d = 2'b11;
               mem_d_d  = {wq_head1.d, wq_head0.d};
               wq_pop2  = 1'b1;
            end
            is_rd_d = 1'b0;
            state_d = WAIT;
         end
         RD: begin
            mem_req_d = ~mem_req_q;
            mem_we_d  = 1'b0;
            mem_a_d   = base_q + AW'(idx_q);
            mem_ds_d  = 2'b11;
            is_rd_d   = 1'b1;
            state_d   = WAIT;
         end
         WAIT: begin
            if (port_free) begin
               state_d = IDLE;
               if (is_rd_q) begin
                  lb_we_d   = 1'b1;
                  lb_addr_d = 10'(idx_q);
                  lb_data_d = mem_q;
                  idx_d     = idx_q + IW'(1);
                  line_done = (idx_q == IW'(LINE_WORDS - 1));
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // A finished line hands over to the pending request before a new one is considered.
      if (line_done) begin
         if (pend_q) begin
            base_d = pbase_q;
            idx_d  = '0;
            pend_d = 1'b0;
         end else begin
            act_d = 1'b0;
         end
      end
      if (line_req) begin
         if (!act_d) begin
            act_d  = 1'b1;
            base_d = line_base;
            idx_d  = '0;
         end else begin
            if (pend_d) ovr_d = 1'b1;
            pend_d  = 1'b1;
            pbase_d = line_base;
         end
      end
   end

   always_ff @(posedge clk_ram) begin
      if (reset) begin
         state_q   <= IDLE;
         rr_q      <= RR_WR;
         is_rd_q   <= 1'b0;
         mem_req_q <= 1'b0;
         mem_we_q  <= 1'b0;
         mem_a_q   <= '0;
         mem_ds_q  <= '0;
         mem_d_q   <= '0;
         lb_we_q   <= 1'b0;
         lb_addr_q <= '0;
         lb_data_q <= '0;
         idx_q     <= '0;
         act_q     <= 1'b0;
         base_q    <= '0;
         pend_q    <= 1'b0;
         pbase_q   <= '0;
         ovr_q     <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         rr_q      <= rr_d;
         is_rd_q   <= is_rd_d;
         mem_req_q <= mem_req_d;
         mem_we_q  <= mem_we_d;
         mem_a_q   <= mem_a_d;
         mem_ds_q  <= mem_ds_d;
         mem_d_q   <= mem_d_d;
         lb_we_q   <= lb_we_d;
         lb_addr_q <= lb_addr_d;
         lb_data_q <= lb_data_d;
         idx_q     <= idx_d;
         act_q     <= act_d;
         base_q    <= base_d;
         pend_q    <= pend_d;
         pbase_q   <= pbase_d;
         ovr_q     <= ovr_d;
         ovf_q     <= ovf_d;
      end
   end

   assign up_ovf    = ovf_q;
   assign line_busy = act_q | lb_we_q;
   assign line_ovr  = ovr_q;
   assign lb_we     = lb_we_q;
   assign lb_addr   = lb_addr_q;
   assign lb_data   = lb_data_q;
   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_a     = mem_a_q;
   assign mem_ds    = mem_ds_q;
   assign mem_d     = mem_d_q;

endmodule

// File: tb/tb_menu_mem_arb.sv
// Directed bench for menu_mem_arb: toggle-handshake memory model, write scoreboard, line-buffer capture.
module tb_menu_mem_arb;

   logic        clk_ram, reset;
   logic        up_wr, up_ovf;
   logic [23:0] up_addr;
   logic [7:0]  up_data;
   logic        line_req, line_busy, line_ovr;
   logic [22:0] line_base;
   logic        lb_we;
   logic [9:0]  lb_addr;
   logic [15:0] lb_data;
   logic        mem_req, mem_ack, mem_we;
   logic [22:0] mem_a;
   logic [1:0]  mem_ds;
   logic [15:0] mem_d, mem_q;

   menu_mem_arb dut (
      .clk_ram   (clk_ram),
      .reset     (reset),
      .up_wr     (up_wr),
      .up_addr   (up_addr),
      .up_data   (up_data),
      .up_ovf    (up_ovf),
      .line_req  (line_req),
      .line_base (line_base),
      .line_busy (line_busy),
      .line_ovr  (line_ovr),
      .lb_we     (lb_we),
      .lb_addr   (lb_addr),
      .lb_data   (lb_data),
      .mem_req   (mem_req),
      .mem_ack   (mem_ack),
      .mem_we    (mem_we),
      .mem_a     (mem_a),
      .mem_ds    (mem_ds),
      .mem_d     (mem_d),
      .mem_q     (mem_q)
   );

   // clock / reset
   initial begin
      clk_ram = 1'b0;
      forever #5 clk_ram = ~clk_ram;
   end

   initial begin
      #800000;
      $display("FAIL global_timeout: observed no finish, expected finish");
      $fatal(1, "global timeout");
   end

   // scoreboard state
   int          n_cmp = 0;
   int          n_fail = 0;
   logic [40:0] exp_q[$];
   logic [40:0] wr_q[$];
   logic [22:0] rd_q[$];
   logic        acc_we_q[$];
   logic [9:0]  lb_addr_q[$];
   logic [15:0] lb_data_q[$];
   int          cyc = 0, last_lb_cyc = 0, fall_cyc = 0, n_falls = 0;
   logic        busy_prev = 1'b0;
   int          lat = 1, lat_cnt = 0;
   logic        freeze = 1'b0, resync = 1'b0;

   // memory model: acknowledges after lat cycles, read data equals the word address
   initial begin
      mem_ack = 1'b0;
      mem_q   = '0;
      forever begin
         @(negedge clk_ram);
         if (resync) begin
            mem_ack = mem_req;
            lat_cnt = 0;
         end else if (!freeze && mem_req != mem_ack) begin
            lat_cnt++;
            if (lat_cnt >= lat) begin
               lat_cnt = 0;
               mem_q   = mem_a[15:0];
               mem_ack = mem_req;
               acc_we_q.push_back(mem_we);
               if (mem_we) wr_q.push_back({mem_a, mem_ds, mem_d});
               else rd_q.push_back(mem_a);
            end
         end
      end
   end

   // line-buffer and line_busy monitor
   initial begin
      forever begin
         @(negedge clk_ram);
         cyc++;
         if (lb_we) begin
            lb_addr_q.push_back(lb_addr);
            lb_data_q.push_back(lb_data);
            last_lb_cyc = cyc;
         end
         if (busy_prev && !line_busy) begin
            fall_cyc = cyc;
            n_falls++;
         end
         busy_prev = line_busy;
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_outs_zero(input string tag);
      check({tag, "_mem_req"}, mem_req, 0);
      check({tag, "_mem_we"}, mem_we, 0);
      check({tag, "_mem_a"}, mem_a, 0);
      check({tag, "_mem_ds"}, mem_ds, 0);
      check({tag, "_mem_d"}, mem_d, 0);
      check({tag, "_lb_we"}, lb_we, 0);
      check({tag, "_lb_addr"}, lb_addr, 0);
      check({tag, "_lb_data"}, lb_data, 0);
      check({tag, "_line_busy"}, line_busy, 0);
      check({tag, "_line_ovr"}, line_ovr, 0);
      check({tag, "_up_ovf"}, up_ovf, 0);
   endtask

   // driver tasks (called at a negedge, return at a negedge)
   task automatic push_byte(input logic [23:0] a, input logic [7:0] d);
      up_wr   = 1'b1;
      up_addr = a;
      up_data = d;
      @(negedge clk_ram);
      up_wr   = 1'b0;
   endtask

   task automatic line_pulse(input logic [22:0] base);
      line_base = base;
      line_req  = 1'b1;
      @(negedge clk_ram);
      line_req  = 1'b0;
   endtask

   task automatic wait_busy_low(input string tag, input int budget);
      int n;
      n = 0;
      while (line_busy && n < budget) begin
         @(negedge clk_ram);
         n++;
      end
      check({tag, "_busy_timeout"}, line_busy, 0);
      repeat (3) @(negedge clk_ram);
   endtask

   function automatic logic [40:0] wexp(input logic [22:0] a, input logic [1:0] ds, input logic [15:0] d);
      return {a, ds, d};
   endfunction

   task automatic check_writes(input string tag);
      check({tag, "_count"}, wr_q.size(), exp_q.size());
      while (exp_q.size() > 0 && wr_q.size() > 0)
         check(tag, wr_q.pop_front(), exp_q.pop_front());
      exp_q.delete();
      wr_q.delete();
   endtask

   task automatic clear_logs();
      wr_q.delete();
      rd_q.delete();
      acc_we_q.delete();
      lb_addr_q.delete();
      lb_data_q.delete();
   endtask

   initial begin
      int bad, n_ww, n_alt, first_rd, last_rd;
      reset = 1'b1; up_wr = 1'b0; up_addr = '0; up_data = '0;
      line_req = 1'b0; line_base = '0;
      repeat (3) @(negedge clk_ram);
      check_outs_zero("reset");
      reset = 1'b0;
      @(negedge clk_ram);

      // two bytes of one word
      push_byte(24'h000000, 8'h11);
      push_byte(24'h000001, 8'h22);
      repeat (20) @(negedge clk_ram);
`ifdef MENU_MEM_ARB_WRCOMBINE_EN
      exp_q.push_back(wexp(23'h0, 2'b11, 16'h2211));
`else
      exp_q.push_back(wexp(23'h0, 2'b01, 16'h1111));
      exp_q.push_back(wexp(23'h0, 2'b10, 16'h2222));
`endif
      check_writes("byte_pair");
      clear_logs();

      // single line fetch
      lat = 1;
      line_pulse(23'h000100);
      check("busy_after_req", line_busy, 1);
      wait_busy_low("line1", 5000);
      check("line1_lb_count", lb_addr_q.size(), 1024);
      bad = 0;
      for (int i = 0; i < lb_addr_q.size(); i++)
         if (lb_addr_q[i] !== 10'(i) || lb_data_q[i] !== 16'(16'h100 + i)) bad++;
      check("line1_lb_bad", bad, 0);
      check("line1_busy_fall", fall_cyc, last_lb_cyc + 1);
      check("line1_rd_count", rd_q.size(), 1024);
      if (rd_q.size() == 1024) check("line1_rd_last", rd_q[1023], 23'h4FF);
      clear_logs();

      // uploads during a line fetch, latency 2
      lat = 2;
      line_pulse(23'h000000);
      for (int k = 0; k < 60; k++) begin
         push_byte(24'h001000 + 24'(2 * k), 8'(8'hA0 + k));
         exp_q.push_back(wexp(23'h800 + 23'(k), 2'b01, {8'(8'hA0 + k), 8'(8'hA0 + k)}));
         repeat (5) @(negedge clk_ram);
      end
      wait_busy_low("line2", 8000);
      repeat (20) @(negedge clk_ram);
      check("mixed_up_ovf", up_ovf, 0);
      check("mixed_rd_count", rd_q.size(), 1024);
      first_rd = -1; last_rd = -1;
      for (int i = 0; i < acc_we_q.size(); i++)
         if (!acc_we_q[i]) begin
            if (first_rd < 0) first_rd = i;
            last_rd = i;
         end
      n_ww = 0; n_alt = 0;
      for (int i = first_rd; i >= 0 && i < last_rd; i++) begin
         if (acc_we_q[i] && acc_we_q[i+1]) n_ww++;
         if (i + 2 <= last_rd && acc_we_q[i] && !acc_we_q[i+1] && acc_we_q[i+2]) n_alt++;
      end
      check("mixed_forced_wr", n_ww > 0, 1);
      check("mixed_alternate", n_alt > 0, 1);
      check_writes("mixed_writes");
      clear_logs();

      // overflow with memory stalled
      lat = 1;
      freeze = 1'b1;
      push_byte(24'h004000, 8'h50);
      repeat (4) @(negedge clk_ram);
      check("stall_inflight_a", mem_a, 23'h2000);
      exp_q.push_back(wexp(23'h2000, 2'b01, 16'h5050));
      for (int i = 0; i < 9; i++) begin
         push_byte(24'h004002 + 24'(2 * i), 8'(8'h51 + i));
         if (i < 8) exp_q.push_back(wexp(23'h2001 + 23'(i), 2'b01, {8'(8'h51 + i), 8'(8'h51 + i)}));
         if (i == 7) check("ovf_before_drop", up_ovf, 0);
      end
      check("ovf_after_drop", up_ovf, 1);
      freeze = 1'b0;
      repeat (60) @(negedge clk_ram);
      check_writes("ovf_order");
      clear_logs();

      // three requests during one fetch
      check("ovr_initial", line_ovr, 0);
      n_falls = 0;
      line_pulse(23'h004000);
      repeat (10) @(negedge clk_ram);
      line_pulse(23'h005000);
      repeat (10) @(negedge clk_ram);
      line_pulse(23'h006000);
      check("ovr_set", line_ovr, 1);
      wait_busy_low("line3", 9000);
      check("line3_lb_count", lb_addr_q.size(), 2048);
      bad = 0;
      for (int i = 0; i < lb_addr_q.size(); i++) begin
         if (i < 1024) begin
            if (lb_addr_q[i] !== 10'(i) || lb_data_q[i] !== 16'(16'h4000 + i)) bad++;
         end else begin
            if (lb_addr_q[i] !== 10'(i - 1024) || lb_data_q[i] !== 16'(16'h6000 + i - 1024)) bad++;
         end
      end
      check("line3_lb_bad", bad, 0);
      check("line3_one_fall", n_falls, 1);
      if (rd_q.size() == 2048) check("line3_second_base", rd_q[1024], 23'h6000);
      else check("line3_rd_count", rd_q.size(), 2048);
      clear_logs();

      // reset during WAIT
      freeze = 1'b1;
      push_byte(24'h000010, 8'h33);
      repeat (4) @(negedge clk_ram);
      check("rst_inflight_we", mem_we, 1);
      reset = 1'b1;
      @(negedge clk_ram);
      check_outs_zero("rst_mid");
      reset = 1'b0;
      resync = 1'b1;
      repeat (2) @(negedge clk_ram);
      resync = 1'b0;
      freeze = 1'b0;
      clear_logs();
      push_byte(24'h000003, 8'h77);
      repeat (15) @(negedge clk_ram);
      exp_q.push_back(wexp(23'h1, 2'b10, 16'h7777));
      check_writes("post_reset");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
